// File: rtl/qpsk_frame_ctrl.sv
// Frame sequencer feeding the QPSK modulator's 32-bit AXIS input.
// Each accepted command produces: preamble words, then cmd_len payload words, then guard words.
module qpsk_frame_ctrl #(
  parameter int unsigned PRE_WORDS   = 4,
  parameter logic [31:0] PREAMBLE    = 32'hCCCCCCCC,
  parameter int unsigned GUARD_WORDS = 2,
  parameter logic [31:0] GUARD_WORD  = 32'h00000000,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      pl_tdata,
  input  logic             pl_tvalid,
  output logic             pl_tready,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, PAY, GUARD} state_t;

  localparam logic [LEN_W-1:0] PRE_LAST   = LEN_W'(PRE_WORDS - 1);
  localparam logic [LEN_W-1:0] GUARD_LAST = LEN_W'(GUARD_WORDS - 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  // The beat counter compares against the last index (len-1), so a
  // maximum-length payload never needs a count of 2^LEN_W.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    cmd_ready    = 1'b0;
    m_tvalid     = 1'b0;
    m_tdata      = '0;
    pl_tready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          len_d   = cmd_len;
          cnt_d   = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        m_tvalid = 1'b1;
        m_tdata  = PREAMBLE;
        if (m_tready) begin
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = (len_q != '0) ? PAY : GUARD;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      PAY: begin
        m_tdata   = pl_tdata;
        m_tvalid  = pl_tvalid;
        pl_tready = m_tready;
        if (pl_tvalid && m_tready) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            cnt_d   = '0;
            state_d = GUARD;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      GUARD: begin
        m_tvalid = 1'b1;
        m_tdata  = GUARD_WORD;
        if (m_tready) begin
          if (cnt_q == GUARD_LAST) begin
            cnt_d        = '0;
            state_d      = IDLE;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
